// File: rtl/fft_bitrev_reorder_if.sv
// rtl/fft_bitrev_reorder_if.sv - Sample stream bundle between the last FFT stage, the reorder buffer and its consumers
interface fft_bitrev_reorder_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_W     = 6
);
  logic                         in_valid;
  logic                         frame_start;
  logic signed [DATA_WIDTH-1:0] serial_in_r;
  logic signed [DATA_WIDTH-1:0] serial_in_i;
  logic                         out_valid;
  logic                         out_start;
  logic        [ADDR_W-1:0]     out_index;
  logic signed [DATA_WIDTH-1:0] serial_out_r;
  logic signed [DATA_WIDTH-1:0] serial_out_i;
  logic                         frame_err;

  modport master (
    output in_valid, frame_start, serial_in_r, serial_in_i,
    input  out_valid, out_start, out_index, serial_out_r, serial_out_i, frame_err
  );

  modport slave (
    input  in_valid, frame_start, serial_in_r, serial_in_i,
    output out_valid, out_start, out_index, serial_out_r, serial_out_i, frame_err
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - Ping-pong buffer turning bit-reversed FFT output into natural-order frames
// Optional FFT_REORDER_ERR_CNT_EN adds err_count, a saturating count of discarded partial frames.
module fft_bitrev_reorder #(
  parameter int INTEGER_SIZE = 6,
  parameter int FRACT_SIZE   = 12,
  parameter int NFFT         = 64
) (
  input  logic       clk,
  input  logic       rst,
`ifdef FFT_REORDER_ERR_CNT_EN
  output logic [7:0] err_count,
`endif
  fft_bitrev_reorder_if.slave bus
);
  localparam int DATA_WIDTH = INTEGER_SIZE + FRACT_SIZE;
  localparam int ADDR_W     = $clog2(NFFT);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NFFT - 1);

  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int b = 0; b < ADDR_W; b++) begin
      r[b] = a[ADDR_W-1-b];
    end
    return r;
  endfunction

  logic [2*DATA_WIDTH-1:0] mem [2*NFFT];

  logic [ADDR_W-1:0] wr_cnt;
  logic              wr_bank;
  logic              wr_sync;
  logic [1:0]        bank_full;

  logic              wr_en;
  logic              wr_done;
  logic              resync;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        set_mask;
  logic [1:0]        clr_mask;

  rd_state_t         rd_state;
  rd_state_t         rd_state_d;
  logic [ADDR_W-1:0] rd_cnt;
  logic              rd_bank;
  logic              emit;
  logic              rd_last;
  logic [ADDR_W-1:0] emit_idx;
  logic [2*DATA_WIDTH-1:0] rd_word;

  // frame_start always lands at address 0; a mid-frame one restarts the same bank
  always_comb begin
    wr_en    = bus.in_valid && (bus.frame_start || wr_sync);
    resync   = bus.in_valid && bus.frame_start && wr_sync && (wr_cnt != '0);
    wr_addr  = bus.frame_start ? '0 : bitrev(wr_cnt);
    wr_done  = wr_en && !bus.frame_start && (wr_cnt == LAST_IDX);
    set_mask = wr_done ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    clr_mask = rd_last ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= {bus.serial_in_r, bus.serial_in_i};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt        <= '0;
      wr_bank       <= 1'b0;
      wr_sync       <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_err <= resync;
      if (wr_en) begin
        wr_sync <= 1'b1;
        if (bus.frame_start) begin
          wr_cnt <= ADDR_W'(1);
        end else if (wr_done) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full & ~clr_mask) | set_mask;
    end
  end

  // IDLE emits k=0 the edge after a bank fills, so a bank completing during k=NFFT-1 follows with no bubble
  always_comb begin
    rd_state_d = rd_state;
    emit       = 1'b0;
    emit_idx   = rd_cnt;
    rd_last    = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (bank_full[rd_bank]) begin
          emit       = 1'b1;
          emit_idx   = '0;
          rd_state_d = RD_READ;
        end
      end
      RD_READ: begin
        emit = 1'b1;
        if (rd_cnt == LAST_IDX) begin
          rd_last    = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign rd_word = mem[{rd_bank, emit_idx}];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
    end else begin
      rd_state <= rd_state_d;
      if (emit) begin
        rd_cnt <= emit_idx + 1'b1;
      end
      if (rd_last) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid    <= 1'b0;
      bus.out_start    <= 1'b0;
      bus.out_index    <= '0;
      bus.serial_out_r <= '0;
      bus.serial_out_i <= '0;
    end else begin
      bus.out_valid <= emit;
      bus.out_start <= emit && (emit_idx == '0);
      if (emit) begin
        bus.out_index    <= emit_idx;
        bus.serial_out_r <= rd_word[2*DATA_WIDTH-1:DATA_WIDTH];
        bus.serial_out_i <= rd_word[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef FFT_REORDER_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= 8'd0;
    end else if (resync && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - Directed bench for fft_bitrev_reorder with a frame-level reference model
module tb_fft_bitrev_reorder;
  localparam int NFFT = 64;
  localparam int DW   = 18;
  localparam int AW   = 6;

  typedef struct {
    int cyc;
    int idx;
    int r;
    int i;
  } exp_t;

  logic clk;
  logic rst;
`ifdef FFT_REORDER_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  fft_bitrev_reorder_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  fft_bitrev_reorder #(.INTEGER_SIZE(6), .FRACT_SIZE(12), .NFFT(NFFT)) dut (
    .clk (clk),
    .rst (rst),
`ifdef FFT_REORDER_ERR_CNT_EN
    .err_count (err_count),
`endif
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rev(input int k);
    int x = k;
    int r = 0;
    for (int b = 0; b < AW; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // Reference model: collect a frame's samples in arrival order, emit natural order one edge after completion
  int   cyc = 0;
  int   last_cap = 0;
  int   n_err_model = 0;
  bit   m_sync = 0;
  int   fr_q[$];
  int   fi_q[$];
  exp_t exp_q[$];
  int   err_q[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      m_sync = 0;
      n_err_model = 0;
      fr_q.delete();
      fi_q.delete();
    end else if (bus.in_valid) begin
      last_cap = cyc;
      if (bus.frame_start) begin
        if (m_sync && fr_q.size() != 0) begin
          err_q.push_back(cyc);
          n_err_model++;
        end
        m_sync = 1;
        fr_q.delete();
        fi_q.delete();
      end
      if (m_sync) begin
        fr_q.push_back(int'(bus.serial_in_r));
        fi_q.push_back(int'(bus.serial_in_i));
      end
      if (fr_q.size() == NFFT) begin
        for (int k = 0; k < NFFT; k++) begin
          exp_t e;
          e.cyc = cyc + 1 + k;
          e.idx = k;
          e.r   = fr_q[rev(k)];
          e.i   = fi_q[rev(k)];
          exp_q.push_back(e);
        end
        fr_q.delete();
        fi_q.delete();
      end
    end
  end

  int   n_valid = 0;
  int   n_start = 0;
  int   n_err_pulse = 0;
  int   run = 0;
  int   max_run = 0;
  int   first_valid_cyc = -1;
  int   cap_r [NFFT];
  int   cap_i [NFFT];
  exp_t ce;

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      ce = exp_q.pop_front();
      chk("out_valid", bus.out_valid, 1);
      chk("out_index", bus.out_index, ce.idx);
      chk("out_start", bus.out_start, (ce.idx == 0) ? 1 : 0);
      chk("serial_out_r", int'(bus.serial_out_r), ce.r);
      chk("serial_out_i", int'(bus.serial_out_i), ce.i);
    end else begin
      chk("out_valid_idle", bus.out_valid, 0);
    end
    if (err_q.size() > 0 && err_q[0] == cyc) begin
      void'(err_q.pop_front());
      chk("frame_err_pulse", bus.frame_err, 1);
    end else begin
      chk("frame_err_idle", bus.frame_err, 0);
    end
`ifdef FFT_REORDER_ERR_CNT_EN
    chk("err_count", err_count, (n_err_model > 255) ? 255 : n_err_model);
`endif
    if (bus.out_valid) begin
      n_valid++;
      run++;
      if (run > max_run) max_run = run;
      if (bus.out_start) n_start++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      cap_r[bus.out_index] = int'(bus.serial_out_r);
      cap_i[bus.out_index] = int'(bus.serial_out_i);
    end else begin
      run = 0;
    end
    if (bus.frame_err) n_err_pulse++;
  end

  task automatic drive(input bit v, input bit s, input int r, input int i);
    @(posedge clk);
    #1;
    bus.in_valid    = v;
    bus.frame_start = s;
    bus.serial_in_r = DW'(r);
    bus.serial_in_i = DW'(i);
  endtask

  task automatic send_frame(input int base, input bit gaps, input bit with_start);
    for (int n = 0; n < NFFT; n++) begin
      drive(1'b1, with_start && (n == 0), base + n, -(base + n));
      if (gaps) drive(1'b0, 1'b0, 0, 0);
    end
    drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic clear_mon();
    n_valid = 0;
    n_start = 0;
    n_err_pulse = 0;
    max_run = 0;
    first_valid_cyc = -1;
  endtask

  initial begin
    bit found;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.serial_in_r = '0;
    bus.serial_in_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_start", bus.out_start, 0);
    chk("reset_out_index", bus.out_index, 0);
    chk("reset_serial_out_r", int'(bus.serial_out_r), 0);
    chk("reset_serial_out_i", int'(bus.serial_out_i), 0);
    chk("reset_frame_err", bus.frame_err, 0);
`ifdef FFT_REORDER_ERR_CNT_EN
    chk("reset_err_count", err_count, 0);
`endif
    rst = 1'b1;

    // Pre-sync samples are dropped, then one clean frame
    clear_mon();
    for (int n = 0; n < 5; n++) drive(1'b1, 1'b0, 777, -777);
    send_frame(0, 1'b0, 1'b1);
    repeat (70) @(posedge clk);
    chk("single_latency", first_valid_cyc - last_cap, 1);
    chk("single_k1_r", cap_r[1], 32);
    chk("single_k1_i", cap_i[1], -32);
    chk("single_k3_r", cap_r[3], 48);
    chk("single_k63_r", cap_r[63], 63);
    chk("single_count", n_valid, 64);

    // Back-to-back frames keep out_valid high for two frames
    clear_mon();
    for (int n = 0; n < NFFT; n++) drive(1'b1, n == 0, n, -n);
    send_frame(100, 1'b0, 1'b1);
    repeat (140) @(posedge clk);
    chk("b2b_run", max_run, 128);
    chk("b2b_starts", n_start, 2);
    chk("b2b_k1_r", cap_r[1], 132);

    // in_valid toggling every other cycle
    clear_mon();
    send_frame(0, 1'b1, 1'b1);
    repeat (70) @(posedge clk);
    chk("gap_latency", first_valid_cyc - last_cap, 1);
    chk("gap_k1_r", cap_r[1], 32);
    chk("gap_k3_r", cap_r[3], 48);
    chk("gap_k63_i", cap_i[63], -63);

    // Resync at wr_cnt=20 followed by a clean frame
    clear_mon();
    for (int n = 0; n < 20; n++) drive(1'b1, n == 0, 500 + n, -(500 + n));
    send_frame(200, 1'b0, 1'b1);
    repeat (70) @(posedge clk);
    chk("resync_err_pulses", n_err_pulse, 1);
    chk("resync_out_count", n_valid, 64);
    chk("resync_k1_r", cap_r[1], 232);
    chk("resync_k0_r", cap_r[0], 200);
`ifdef FFT_REORDER_ERR_CNT_EN
    chk("resync_err_count", err_count, 1);
`endif

    // Asynchronous reset in the middle of a read
    send_frame(300, 1'b0, 1'b1);
    found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_index == AW'(10)) found = 1;
    end
    chk("rst_wait_k10", found, 1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    err_q.delete();
    #1;
    chk("rst_async_out_valid", bus.out_valid, 0);
    chk("rst_async_out_index", bus.out_index, 0);
    chk("rst_async_serial_out_r", int'(bus.serial_out_r), 0);
    chk("rst_async_serial_out_i", int'(bus.serial_out_i), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_mon();
    send_frame(400, 1'b0, 1'b0);
    repeat (80) @(posedge clk);
    chk("post_rst_no_output", n_valid, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output reorder buffer at the tail of the SDF FFT pipeline.
- Consumes the serial stream from the last FFT stage, which arrives in bit-reversed index order, one complex sample per valid cycle.
- Writes each sample into a ping-pong sample memory at its bit-reversed address, then streams each completed frame out in natural order (X[0]..X[NFFT-1]) to downstream consumers.

Parameters:
- INTEGER_SIZE, 6, integer bits of each signed fixed-point component
- FRACT_SIZE, 12, fractional bits of each component; DATA_WIDTH = INTEGER_SIZE+FRACT_SIZE
- NFFT, 64, frame length; power of two, 4..1024; ADDR_W = log2(NFFT)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous and active-low
- in_valid  in  1  serial_in_r/i carry a sample this cycle
- frame_start  in  1  qualified by in_valid; this sample is bit-reversed index 0 of a new frame
- serial_in_r  in  DATA_WIDTH  signed real part, bit-reversed order
- serial_in_i  in  DATA_WIDTH  signed imaginary part
- out_valid  out  1  output sample valid
- out_start  out  1  with out_valid, marks natural index 0
- out_index  out  ADDR_W  natural-order index of the current output
- serial_out_r  out  DATA_WIDTH  signed real part, natural order
- serial_out_i  out  DATA_WIDTH  signed imaginary part
- frame_err  out  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; wr_cnt=0; wr_bank=0; no bank full; reader idle; wr_sync=0. Memory contents are not reset.
- Write side, on each in_valid edge:
  - mem[wr_bank][bitrev(wr_cnt)] <= input; wr_cnt increments.
  - Samples with in_valid=1 arriving before the first frame_start (wr_sync=0) are ignored.
  - frame_start sets wr_sync=1 and forces the write address to bitrev(0)=0.
- Frame completion: when the sample with wr_cnt=NFFT-1 is written at edge E:
  - wr_bank marked full, wr_bank toggles, wr_cnt wraps to 0.
- frame_start with wr_cnt != 0 (resync mid-frame): partial data in the current bank is discarded. The sample is written at address 0 of the same bank, wr_cnt=1, and frame_err pulses for 1 cycle. This never corrupts a bank being read.
- Read side: reader is IDLE or READ.
  - IDLE -> READ at the edge after a bank becomes full (E+1).
  - At edge E+1+k (k=0..NFFT-1), outputs register mem[rd_bank][k] with out_valid=1, out_index=k, and out_start=(k==0).
- Latency: the natural-order X[0] appears 1 edge after the last input sample is captured; the full frame drains in NFFT consecutive cycles. There is no backpressure.
- Back-to-back frames: the next bank may complete at the same edge the reader emits k=NFFT-1. The reader then continues directly with k=0 of the new bank (out_valid stays high, no bubble). Otherwise READ -> IDLE after k=NFFT-1, and outputs hold their last value with out_valid=0.
- Input gaps (in_valid=0) stall only the write side; they never affect a frame already being read.
- Overflow is impossible, because writing a frame takes >= NFFT cycles and draining takes exactly NFFT cycles.
- Arithmetic: data is stored and forwarded unmodified, bit-exact, signed DATA_WIDTH.
- Reset mid-operation: all state is dropped immediately. After release, the block waits for a new frame_start.

Optional Feature:
- Macro: FFT_REORDER_ERR_CNT_EN.
- When defined: adds output port err_count [7:0]. It is reset to 0, increments on every frame_err pulse, and saturates at 255.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single frame, NFFT=64: feed input n with r=n, i=-n, frame_start at n=0, continuous valid. Natural index k must carry value bitrev6(k): k=1 -> r=32, i=-32; k=3 -> r=48; k=63 -> r=63. First out_valid is at the edge after the last input.
- Two back-to-back frames (second frame values +100): out_valid stays high for 128 consecutive cycles; out_start at k=0 of each frame; the second frame k=1 gives r=132.
- Input with in_valid toggling every other cycle: output is identical to the single-frame case and starts 1 edge after the 64th valid sample.
- frame_start re-asserted at wr_cnt=20, then a full clean frame: frame_err pulses once; only the clean frame is output, correctly ordered. With FFT_REORDER_ERR_CNT_EN, err_count=1.
- rst asserted low mid-read (k=10): out_valid=0 and all outputs 0 immediately (asynchronously). Valid data without frame_start after release yields no output.
- Pre-sync data: 5 valid samples before the first frame_start are ignored; the following frame is output correctly.
